sobel_frame_ctrl: RTL and testbench

//  Frame-level controller for the Sobel edge stage. It shadows the edge threshold and enable so they

---
 rtl/sobel_frame_ctrl_if.sv | 31 +++
 rtl/sobel_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_frame_ctrl_if.sv
// Bundle of the config, Sobel stream and per-frame result signals of sobel_frame_ctrl.
// The master drives config and stream and observes results. The slave is the controller.
interface sobel_frame_ctrl_if #(
  parameter int CNT_W = 20
);
  logic             cfg_wr;
  logic [10:0]      cfg_thresh;
  logic             cfg_en;
  logic             in_vsync;
  logic             in_href;
  logic             in_clken;
  logic             in_bit;
  logic [10:0]      thresh_act;
  logic             sobel_en;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] edge_count;
  logic             pix_err;
  logic             line_err;
  logic [15:0]      frame_cnt;

  modport master (
    output cfg_wr, cfg_thresh, cfg_en, in_vsync, in_href, in_clken, in_bit,
    input  thresh_act, sobel_en, busy, frame_done, edge_count, pix_err, line_err, frame_cnt
  );

  modport slave (
    input  cfg_wr, cfg_thresh, cfg_en, in_vsync, in_href, in_clken, in_bit,
    output thresh_act, sobel_en, busy, frame_done, edge_count, pix_err, line_err, frame_cnt
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame-level controller for the Sobel edge stage. Threshold and enable are shadowed so they
// change only on a frame start. Frame geometry is checked, edge pixels are counted, and results
// are published once per frame with a one-cycle done pulse.
module sobel_frame_ctrl #(
  parameter int IMG_HDISP      = 1024,
  parameter int IMG_VDISP      = 720,
  parameter int THRESH_DEFAULT = 80,
  parameter int CNT_W          = 20
) (
  input  logic               clk,
  input  logic               rst,
  sobel_frame_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE, DONE} state_e;

  localparam logic [10:0]      HDISP    = 11'(IMG_HDISP);
  localparam logic [11:0]      VDISP    = 12'(IMG_VDISP);
  localparam logic [10:0]      THR_RST  = 11'(THRESH_DEFAULT);
  localparam logic [10:0]      PIX_MAX  = '1;
  localparam logic [11:0]      LINE_MAX = '1;
  localparam logic [CNT_W-1:0] EDGE_MAX = '1;

  state_e           state_q, state_d;
  logic             vs_q, hr_q;
  logic [10:0]      pend_thresh_q, pend_thresh_d;
  logic             pend_en_q, pend_en_d;
  logic [10:0]      thresh_act_q, thresh_act_d;
  logic             sobel_en_q, sobel_en_d;
  logic [10:0]      pix_w_q, pix_w_d;
  logic [11:0]      line_w_q, line_w_d;
  logic [CNT_W-1:0] edge_w_q, edge_w_d;
  logic             pix_err_w_q, pix_err_w_d;
  logic [CNT_W-1:0] edge_count_q, edge_count_d;
  logic             pix_err_q, pix_err_d;
  logic             line_err_q, line_err_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             vs_rise, vs_fall, hr_fall, beat;
  logic [10:0]      pix_nx;
  logic [11:0]      line_nx;
  logic [CNT_W-1:0] edge_nx;
  logic             pix_err_nx;

  assign vs_rise = bus.in_vsync & ~vs_q;
  assign vs_fall = ~bus.in_vsync & vs_q;
  assign hr_fall = ~bus.in_href & hr_q;
  assign beat    = bus.in_clken & bus.in_href;

  // Working-counter update for this cycle. A line ending on the vs_fall cycle is folded in here,
  // so the result compare below sees it.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    pix_nx     = pix_w_q;
    line_nx    = line_w_q;
    edge_nx    = edge_w_q;
    pix_err_nx = pix_err_w_q;
    if (hr_fall) begin
      pix_err_nx = pix_err_w_q | (pix_w_q != HDISP);
      line_nx    = (line_w_q == LINE_MAX) ? line_w_q : line_w_q + 12'd1;
      pix_nx     = '0;
    end else if (beat && pix_w_q != PIX_MAX) begin
      pix_nx = pix_w_q + 11'd1;
    end
    if (beat && bus.in_bit && edge_w_q != EDGE_MAX) begin
      edge_nx = edge_w_q + 1'b1;
    end
  end

  // Next-state, shadow-register and result logic of the frame FSM.
  always_comb begin
    state_d       = state_q;
    pend_thresh_d = pend_thresh_q;
    pend_en_d     = pend_en_q;
    thresh_act_d  = thresh_act_q;
    sobel_en_d    = sobel_en_q;
    pix_w_d       = pix_w_q;
    line_w_d      = line_w_q;
    edge_w_d      = edge_w_q;
    pix_err_w_d   = pix_err_w_q;
    edge_count_d  = edge_count_q;
    pix_err_d     = pix_err_q;
    line_err_d    = line_err_q;
    frame_cnt_d   = frame_cnt_q;

    // A write on the frame-start cycle lands after the shadow copy below reads the old value.
    if (bus.cfg_wr) begin
      pend_thresh_d = bus.cfg_thresh;
      pend_en_d     = bus.cfg_en;
    end

    case (state_q)
      IDLE: if (pend_en_q) state_d = ARM;
      ARM: begin
        if (!pend_en_q) begin
          state_d = IDLE;
        end else if (vs_rise) begin
          state_d      = ACTIVE;
          thresh_act_d = pend_thresh_q;
          sobel_en_d   = 1'b1;
          pix_w_d      = '0;
          line_w_d     = '0;
          edge_w_d     = '0;
          pix_err_w_d  = 1'b0;
        end
      end
      ACTIVE: begin
        pix_w_d     = pix_nx;
        line_w_d    = line_nx;
        edge_w_d    = edge_nx;
        pix_err_w_d = pix_err_nx;
        if (vs_fall) begin
          state_d      = DONE;
          edge_count_d = edge_nx;
          pix_err_d    = pix_err_nx;
          line_err_d   = (line_nx != VDISP);
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end
      end
      DONE: begin
        if (pend_en_q) begin
          state_d = ARM;
        end else begin
          state_d    = IDLE;
          sobel_en_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, edge-detect and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      vs_q          <= 1'b0;
      hr_q          <= 1'b0;
      pend_thresh_q <= THR_RST;
      pend_en_q     <= 1'b0;
      thresh_act_q  <= THR_RST;
      sobel_en_q    <= 1'b0;
      pix_w_q       <= '0;
      line_w_q      <= '0;
      edge_w_q      <= '0;
      pix_err_w_q   <= 1'b0;
      edge_count_q  <= '0;
      pix_err_q     <= 1'b0;
      line_err_q    <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      vs_q          <= bus.in_vsync;
      hr_q          <= bus.in_href;
      pend_thresh_q <= pend_thresh_d;
      pend_en_q     <= pend_en_d;
      thresh_act_q  <= thresh_act_d;
      sobel_en_q    <= sobel_en_d;
      pix_w_q       <= pix_w_d;
      line_w_q      <= line_w_d;
      edge_w_q      <= edge_w_d;
      pix_err_w_q   <= pix_err_w_d;
      edge_count_q  <= edge_count_d;
      pix_err_q     <= pix_err_d;
      line_err_q    <= line_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.thresh_act = thresh_act_q;
  assign bus.sobel_en   = sobel_en_q;
  assign bus.busy       = (state_q == ACTIVE);
  assign bus.frame_done = (state_q == DONE);
  assign bus.edge_count = edge_count_q;
  assign bus.pix_err    = pix_err_q;
  assign bus.line_err   = line_err_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl with a 4x3 image and a 4-bit edge counter.
module tb_sobel_frame_ctrl;

  localparam int HD = 4;
  localparam int VD = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   exp_frames = 0;
  int   d0;

  sobel_frame_ctrl_if #(.CNT_W(CW)) bus ();

  sobel_frame_ctrl #(
    .IMG_HDISP(HD), .IMG_VDISP(VD), .THRESH_DEFAULT(80), .CNT_W(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count done pulses mid-cycle.
  always @(negedge clk) if (bus.frame_done === 1'b1) done_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          nlines;
    int          bad_line;
    int          bad_beats;
    int          nedges;
    bit          rise_wr;
    bit          mid_wr;
    logic [10:0] wr_thr;
    bit          wr_en;
    logic [10:0] exp_thr;
    int          exp_edge;
    bit          exp_pe;
    bit          exp_le;
    bit          exp_en_after;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cfg(input logic [10:0] thr, input bit en);
    bus.cfg_wr     = 1'b1;
    bus.cfg_thresh = thr;
    bus.cfg_en     = en;
  endtask

  // Drive one cycle of stream inputs, then land 1 time unit after the next rising edge.
  task automatic step(input logic vs, input logic hr, input logic ck, input logic b);
    bus.in_vsync = vs;
    bus.in_href  = hr;
    bus.in_clken = ck;
    bus.in_bit   = b;
    @(posedge clk);
    #1;
    bus.cfg_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // One frame: vsync-rise cycle, lines of beats each followed by an href-low cycle, vsync-fall cycle.
  task automatic run_frame(input int nlines, input int bad_line, input int bad_beats,
                           input int nedges, input bit rise_wr, input bit mid_wr,
                           input logic [10:0] wr_thr, input bit wr_en);
    int e;
    int nb;
    e = nedges;
    if (rise_wr) cfg(wr_thr, wr_en);
    step(1, 0, 0, 0);
    for (int l = 0; l < nlines; l++) begin
      nb = (l == bad_line) ? bad_beats : HD;
      for (int b = 0; b < nb; b++) begin
        if (mid_wr && l == 1 && b == 1) cfg(wr_thr, wr_en);
        step(1, 1, 1, e > 0);
        if (e > 0) e--;
      end
      step(1, 0, 0, 0);
    end
    step(0, 0, 0, 0);
  endtask

  initial begin
    vecs[0] = '{3, -1, 0,  5, 0, 0, 11'd0,  0, 11'd100,  5, 0, 0, 1};
    vecs[1] = '{2,  1, 3,  2, 0, 0, 11'd0,  0, 11'd100,  2, 1, 1, 1};
    vecs[2] = '{3, -1, 0,  0, 0, 0, 11'd0,  0, 11'd100,  0, 0, 0, 1};
    vecs[3] = '{5, -1, 0, 20, 0, 0, 11'd0,  0, 11'd100, 15, 0, 1, 1};
    vecs[4] = '{3,  0, 5,  7, 0, 0, 11'd0,  0, 11'd100,  7, 1, 0, 1};
    vecs[5] = '{3, -1, 0,  4, 1, 1, 11'd50, 1, 11'd100,  4, 0, 0, 1};
    vecs[6] = '{3, -1, 0, 12, 0, 0, 11'd0,  0, 11'd50,  12, 0, 0, 1};
    vecs[7] = '{3, -1, 0,  1, 0, 1, 11'd50, 0, 11'd50,   1, 0, 0, 0};

    bus.cfg_wr = 0; bus.cfg_thresh = 0; bus.cfg_en = 0;
    bus.in_vsync = 0; bus.in_href = 0; bus.in_clken = 0; bus.in_bit = 0;

    // Reset values.
    #12;
    check("rst_thresh", 32'(bus.thresh_act), 80);
    check("rst_sobel_en", 32'(bus.sobel_en), 0);
    check("rst_frame_done", 32'(bus.frame_done), 0);
    check("rst_edge_count", 32'(bus.edge_count), 0);
    check("rst_frame_cnt", 32'(bus.frame_cnt), 0);
    check("rst_busy", 32'(bus.busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    cfg(11'd100, 1'b1);
    step(0, 0, 0, 0);
    idle(3);

    // Table of full frames.
    for (int i = 0; i < 8; i++) begin
      d0 = done_cnt;
      run_frame(vecs[i].nlines, vecs[i].bad_line, vecs[i].bad_beats, vecs[i].nedges,
                vecs[i].rise_wr, vecs[i].mid_wr, vecs[i].wr_thr, vecs[i].wr_en);
      exp_frames++;
      check($sformatf("v%0d_frame_done", i), 32'(bus.frame_done), 1);
      check($sformatf("v%0d_thresh", i), 32'(bus.thresh_act), 32'(vecs[i].exp_thr));
      check($sformatf("v%0d_edge_count", i), 32'(bus.edge_count), vecs[i].exp_edge);
      check($sformatf("v%0d_pix_err", i), 32'(bus.pix_err), 32'(vecs[i].exp_pe));
      check($sformatf("v%0d_line_err", i), 32'(bus.line_err), 32'(vecs[i].exp_le));
      check($sformatf("v%0d_frame_cnt", i), 32'(bus.frame_cnt), exp_frames);
      check($sformatf("v%0d_sobel_en_done", i), 32'(bus.sobel_en), 1);
      step(0, 0, 0, 0);
      check($sformatf("v%0d_pulse_end", i), 32'(bus.frame_done), 0);
      check($sformatf("v%0d_done_pulses", i), done_cnt - d0, 1);
      check($sformatf("v%0d_sobel_en_after", i), 32'(bus.sobel_en), 32'(vecs[i].exp_en_after));
      idle(2);
    end

    // Stage disabled: a full frame produces nothing.
    d0 = done_cnt;
    run_frame(3, -1, 0, 2, 0, 0, 11'd0, 0);
    idle(2);
    check("off_no_done", done_cnt - d0, 0);
    check("off_frame_cnt", 32'(bus.frame_cnt), exp_frames);
    check("off_sobel_en", 32'(bus.sobel_en), 0);
    check("off_thresh", 32'(bus.thresh_act), 50);

    // Arm raised while vsync already high: the partial frame is ignored.
    d0 = done_cnt;
    step(1, 0, 0, 0);
    cfg(11'd50, 1'b1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int l = 0; l < 2; l++) begin
      for (int b = 0; b < HD; b++) step(1, 1, 1, 1);
      step(1, 0, 0, 0);
    end
    check("partial_busy", 32'(bus.busy), 0);
    step(0, 0, 0, 0);
    idle(2);
    check("partial_no_done", done_cnt - d0, 0);
    check("partial_frame_cnt", 32'(bus.frame_cnt), exp_frames);

    d0 = done_cnt;
    run_frame(3, -1, 0, 3, 0, 0, 11'd0, 0);
    exp_frames++;
    check("rearm_edge_count", 32'(bus.edge_count), 3);
    check("rearm_frame_cnt", 32'(bus.frame_cnt), exp_frames);
    idle(3);
    check("rearm_done_pulses", done_cnt - d0, 1);

    // Reset mid-frame, released while vsync is high.
    step(1, 0, 0, 0);
    check("mid_busy", 32'(bus.busy), 1);
    for (int b = 0; b < HD; b++) step(1, 1, 1, 1);
    rst = 1'b1;
    #1;
    check("mrst_thresh", 32'(bus.thresh_act), 80);
    check("mrst_frame_cnt", 32'(bus.frame_cnt), 0);
    check("mrst_edge_count", 32'(bus.edge_count), 0);
    check("mrst_sobel_en", 32'(bus.sobel_en), 0);
    check("mrst_busy", 32'(bus.busy), 0);
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    rst = 1'b0;
    d0 = done_cnt;
    cfg(11'd60, 1'b1);
    step(1, 1, 1, 1);
    step(1, 0, 0, 0);
    for (int b = 0; b < HD; b++) step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    idle(2);
    check("mrst_no_done", done_cnt - d0, 0);
    check("mrst_frame_cnt_hold", 32'(bus.frame_cnt), 0);

    d0 = done_cnt;
    run_frame(3, -1, 0, 6, 0, 0, 11'd0, 0);
    check("post_rst_thresh", 32'(bus.thresh_act), 60);
    check("post_rst_edge_count", 32'(bus.edge_count), 6);
    check("post_rst_pix_err", 32'(bus.pix_err), 0);
    check("post_rst_line_err", 32'(bus.line_err), 0);
    check("post_rst_frame_cnt", 32'(bus.frame_cnt), 1);
    idle(2);
    check("post_rst_done_pulses", done_cnt - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
